// File: rtl/waveform_meter_pkg.sv
// Purpose: shared types and defaults for the waveform period meter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package waveform_meter_pkg;

    // Measurement FSM states; Busy is derived from HIGH/LOW.
    typedef enum logic [2:0] {
        IDLE,
        SEEK_LOW,
        SEEK_RISE,
        HIGH,
        LOW
    } meter_state_t;

    localparam int DEFAULT_CNT_W       = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/edge_sync.sv
// Purpose: synchronise an asynchronous level into Clock and flag its rising/falling edges.
// Latency: level appears SYNC_STAGES cycles after din is sampled; rise/fall are combinational from the flops.
// Backpressure: none; free-running, edges are single-cycle pulses.
module edge_sync
    import waveform_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/waveform_meter.sv
// Purpose: measure high/low time of each full period of WaveIn, publish with a 1-cycle Valid strobe.
// Latency: Valid one cycle after the closing synchronised rise (SYNC_STAGES+2 cycles from raw rise).
// Backpressure: none; results overwrite HighLen/LowLen each period, Overflow discards an over-long phase.
module waveform_meter
    import waveform_meter_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             WaveIn,
    output logic [CNT_W-1:0] HighLen,
    output logic [CNT_W-1:0] LowLen,
    output logic             Valid,
    output logic             Overflow,
    output logic             Busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    meter_state_t     state;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;
    logic             ws;
    logic             rise;
    logic             fall;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .Clock (Clock),
        .Reset (Reset),
        .din   (WaveIn),
        .level (ws),
        .rise  (rise),
        .fall  (fall)
    );

    // Period FSM: arm, discard the partial first period, then count high/low phases back to back.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            hcnt     <= '0;
            lcnt     <= '0;
            HighLen  <= '0;
            LowLen   <= '0;
            Valid    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Valid    <= 1'b0;
            Overflow <= 1'b0;
            if (!Enable) begin
                state <= IDLE;
                hcnt  <= '0;
                lcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SEEK_LOW;
                    end
                    SEEK_LOW: begin
                        // Any high phase in progress at arm time is incomplete; skip it.
                        if (fall) begin
                            state <= SEEK_RISE;
                        end
                    end
                    SEEK_RISE: begin
                        if (rise) begin
                            state <= HIGH;
                            hcnt  <= CNT_ONE;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state <= LOW;
                            lcnt  <= CNT_ONE;
                        end else if (ws) begin
                            if (hcnt == CNT_MAX) begin
                                Overflow <= 1'b1;
                                state    <= SEEK_LOW;
                                hcnt     <= '0;
                                lcnt     <= '0;
                            end else begin
                                hcnt <= hcnt + CNT_ONE;
                            end
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            // Closing rise also opens the next period's high phase.
                            HighLen <= hcnt;
                            LowLen  <= lcnt;
                            Valid   <= 1'b1;
                            state   <= HIGH;
                            hcnt    <= CNT_ONE;
                            lcnt    <= '0;
                        end else if (!ws) begin
                            if (lcnt == CNT_MAX) begin
                                Overflow <= 1'b1;
                                state    <= SEEK_LOW;
                                hcnt     <= '0;
                                lcnt     <= '0;
                            end else begin
                                lcnt <= lcnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        hcnt  <= '0;
                        lcnt  <= '0;
                    end
                endcase
            end
        end
    end

    // Busy reflects an in-progress measurement only, not the seek states.
    always_comb begin
        Busy = (state == HIGH) || (state == LOW);
    end

endmodule
